// File: rtl/bootrom_pkg.sv
// bootrom_pkg: constants and response type for the boot pROM reader; BOOTROM_OREG_EN selects the registered-output pROM
package bootrom_pkg;
  localparam logic [31:0] BOOTROM_BASE = 32'h0000_0000;
  localparam int BOOTROM_WORDS = 1024;
  localparam int BOOTROM_DATA_W = 32;
`ifdef BOOTROM_OREG_EN
  localparam int ROM_LAT = 2;
`else
  localparam int ROM_LAT = 1;
`endif
  typedef struct packed {
    logic err;
    logic [BOOTROM_DATA_W-1:0] data;
  } rsp_t;
endpackage

// File: rtl/bootrom_rsp_fifo.sv
// bootrom_rsp_fifo: in-order response buffer with occupancy count
module bootrom_rsp_fifo
  import bootrom_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  rsp_t          wdata_i,
  input  logic          pop_i,
  output rsp_t          rdata_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  rsp_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= inc(wr_q);
      if (pop_i) rd_q <= inc(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  // storage needs no reset: the top masks the head whenever the buffer is empty
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end
  assign rdata_o = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/bootrom_fetch_port.sv
// bootrom_fetch_port: valid/ready word reader for the 1024x32 boot pROM with in-order buffered responses
// BOOTROM_OREG_EN selects the registered-output pROM (two-cycle ROM latency)
module bootrom_fetch_port
  import bootrom_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BOOTROM_BASE,
  parameter int ADDR_W = 10,
  parameter int DATA_W = BOOTROM_DATA_W,
  parameter int RSP_DEPTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_dout
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int KW = $clog2(RSP_DEPTH + ROM_LAT + 1);
`ifdef BOOTROM_OREG_EN
  if (RSP_DEPTH < 3) $error("RSP_DEPTH must be >= 3 with the registered-output pROM");
`endif
  if (DATA_W != BOOTROM_DATA_W) $error("DATA_W must match BOOTROM_DATA_W");
  logic run_q, hit, accept, pop, push, empty;
  logic [ROM_LAT-1:0] vld_q, err_q;
  logic [KW-1:0] credits;
  logic [CW-1:0] count;
  rsp_t head, last_q, wr_rsp;
  assign hit = (req_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]) && (req_addr[1:0] == 2'b00);
  always_comb begin
    credits = KW'(count);
    for (int i = 0; i < ROM_LAT; i++) credits = credits + KW'(vld_q[i]);
  end
  assign pop = !empty && rsp_ready;
  // every in-flight word already owns a buffer slot, so pipe exit never overflows
  assign req_ready = run_q && (credits < KW'(RSP_DEPTH) || (credits == KW'(RSP_DEPTH) && pop));
  assign accept = req_valid && req_ready;
  assign rom_ce = accept && hit;
  assign rom_ad = rom_ce ? req_addr[ADDR_W+1:2] : '0;
  assign rom_oce = 1'b1;
  assign rom_reset = reset;
  assign push = vld_q[ROM_LAT-1];
  assign wr_rsp = {err_q[ROM_LAT-1], err_q[ROM_LAT-1] ? DATA_W'(0) : rom_dout};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= 1'b0;
      vld_q <= '0;
      err_q <= '0;
      last_q <= '0;
    end else begin
      run_q <= 1'b1;
      vld_q <= ROM_LAT'({vld_q, accept});
      err_q <= ROM_LAT'({err_q, !hit});
      if (pop) last_q <= head;
    end
  end
  bootrom_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push_i(push),
    .wdata_i(wr_rsp),
    .pop_i(pop),
    .rdata_o(head),
    .empty_o(empty),
    .count_o(count)
  );
  assign rsp_valid = !empty;
  assign rsp_data = empty ? last_q.data : head.data;
  assign rsp_err = empty ? last_q.err : head.err;
endmodule
